debug_tx_arbiter: RTL

Shares the single RS-232 transmitter among several debug-console message sources: command echo, help and error strings, `get` replies, and the watch reporter. Each source streams a message one byte at a time. The arbiter grants one source at a time, round-robin, and holds that grant for the whole message, so messages never interleave. It sits between the command/response logic and the RS-232 transmitter's `sendCLK`/`TXData` inputs.

---
 rtl/debug_tx_arbiter_pkg.sv | 26 ++
 rtl/debug_tx_arbiter_if.sv | 44 ++++
 rtl/debug_tx_arbiter_rr_pick.sv | 33 +++
 rtl/debug_tx_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_tx_arbiter_pkg.sv
// Shared types and constants for the debug-console transmit arbiter.
// Optional CR/LF trailer states are built only when DBG_TX_CRLF_EN is defined.
package debug_tx_pkg;

    localparam logic [7:0] DBG_CR = 8'h0D;
    localparam logic [7:0] DBG_LF = 8'h0A;

`ifdef DBG_TX_CRLF_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } dbg_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3
    } dbg_tx_state_t;
`endif

endpackage

// File: rtl/debug_tx_arbiter_if.sv
// Byte-lane request bus and transmitter strobe bundle for debug_tx_arbiter.
// master = arbiter side, slave = sources plus transmitter side.
interface debug_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_ready,
        output req_ready,
        output grant,
        output tx_start,
        output tx_data,
        output busy,
        output timeout_err
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_last,
        output tx_ready,
        input  req_ready,
        input  grant,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  timeout_err
    );

endinterface

// File: rtl/debug_tx_arbiter_rr_pick.sv
// Round-robin first-set-bit finder: searches upward from i_ptr with wrap.
// Purely combinational; o_pick is one-hot or zero.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_any
);

    logic [PW-1:0] w_idx;

    // Walk offsets from far to near so the nearest set bit wins
    always_comb begin
        o_pick = '0;
        o_any  = |i_req;
        w_idx  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (int'(i_ptr) + off >= N) begin
                w_idx = PW'(int'(i_ptr) + off - N);
            end else begin
                w_idx = PW'(int'(i_ptr) + off);
            end
            if (i_req[w_idx]) begin
                o_pick        = '0;
                o_pick[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_tx_arbiter.sv
// Round-robin arbiter sharing one RS-232 transmitter among message sources.
// Define DBG_TX_CRLF_EN to append CR/LF after every completed message.
module debug_tx_arbiter
    import debug_tx_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               MainCLK,
    input  logic               RST,
    debug_tx_arbiter_if.master bus
);

    localparam int PW = $clog2(NUM_REQ);

    dbg_tx_state_t       r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_gidx;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_byte;
    logic                r_last;
    logic [7:0]          r_stall;
    logic                r_hold;
    logic                r_timeout_err;
`ifdef DBG_TX_CRLF_EN
    logic                r_sent;
`endif

    logic [NUM_REQ-1:0]  w_pick;
    logic                w_any;
    logic [PW-1:0]       w_pick_idx;
    logic [PW-1:0]       w_next_ptr;
    logic                w_gvalid;
    logic                w_glast;
    logic [7:0]          w_gdata;
    logic                w_tx_start;
    logic [7:0]          w_tx_data;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .i_req  (bus.req_valid),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    // Encode the one-hot pick and select the granted lane's signals
    always_comb begin
        w_pick_idx = '0;
        w_gdata    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = PW'(k);
            end
            if (r_grant[k]) begin
                w_gdata = w_gdata | bus.req_data[8*k +: 8];
            end
        end
        w_gvalid = |(bus.req_valid & r_grant);
        w_glast  = |(bus.req_last & r_grant);
        if (r_gidx == PW'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_gidx + PW'(1);
        end
    end

    // Transmitter strobe and byte mux; strobe only when the UART is idle
    always_comb begin
        w_tx_start = 1'b0;
        w_tx_data  = r_byte;
        case (r_state)
            ST_SEND: w_tx_start = bus.tx_ready;
`ifdef DBG_TX_CRLF_EN
            ST_CR: begin
                w_tx_start = bus.tx_ready & ~r_sent;
                w_tx_data  = DBG_CR;
            end
            ST_LF: begin
                w_tx_start = bus.tx_ready & ~r_sent;
                w_tx_data  = DBG_LF;
            end
`endif
            default: ;
        endcase
    end

    assign bus.req_ready   = (r_state == ST_FETCH) ?
                             (bus.req_valid & r_grant) : '0;
    assign bus.grant       = r_grant;
    assign bus.tx_start    = w_tx_start;
    assign bus.tx_data     = w_tx_data;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.timeout_err = r_timeout_err;

    // Message FSM: grant, fetch, send, wait for frame, release
    always_ff @(posedge MainCLK) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gidx        <= '0;
            r_grant       <= '0;
            r_byte        <= '0;
            r_last        <= 1'b0;
            r_stall       <= '0;
            r_hold        <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef DBG_TX_CRLF_EN
            r_sent        <= 1'b0;
`endif
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_stall <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_gvalid) begin
                        r_byte  <= w_gdata;
                        r_last  <= w_glast;
                        r_stall <= '0;
                        if (w_gdata != 8'h00) begin
                            r_state <= ST_SEND;
                        end else if (w_glast) begin
                            r_ptr   <= w_next_ptr;
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_stall == 8'(TIMEOUT - 1)) begin
                        // Source went quiet: revoke without a trailer
                        r_stall       <= 8'(TIMEOUT);
                        r_timeout_err <= 1'b1;
                        r_ptr         <= w_next_ptr;
                        r_grant       <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_stall <= r_stall + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        r_hold  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // tx_ready is stale on the cycle right after a strobe
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (bus.tx_ready) begin
                        if (!r_last) begin
                            r_state <= ST_FETCH;
                        end else begin
`ifdef DBG_TX_CRLF_EN
                            r_sent  <= 1'b0;
                            r_state <= ST_CR;
`else
                            r_ptr   <= w_next_ptr;
                            r_grant <= '0;
                            r_state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef DBG_TX_CRLF_EN
                ST_CR: begin
                    if (!r_sent) begin
                        if (bus.tx_ready) begin
                            r_sent <= 1'b1;
                            r_hold <= 1'b1;
                        end
                    end else if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (bus.tx_ready) begin
                        r_sent  <= 1'b0;
                        r_state <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (!r_sent) begin
                        if (bus.tx_ready) begin
                            r_sent <= 1'b1;
                            r_hold <= 1'b1;
                        end
                    end else if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (bus.tx_ready) begin
                        r_sent  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
